dmi_req_arbiter: RTL

//  Shares the single DMI slave port of the RISC-V debug module between NUM_REQ DMI masters
//  (port 0: JTAG DTM; port 1+: on-chip/SPI debug bridges). One transaction outstanding at a time,

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dmi_rr_pick.sv | 34 +++
 rtl/dmi_req_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared DMI request/response types and encodings for the debug module fabric.
package dm_pkg;

  localparam int DMI_ADDR_W = 7;

  localparam logic [1:0] DMI_OP_NOP   = 2'b00;
  localparam logic [1:0] DMI_OP_READ  = 2'b01;
  localparam logic [1:0] DMI_OP_WRITE = 2'b10;

  localparam logic [1:0] DMI_RESP_OK     = 2'b00;
  localparam logic [1:0] DMI_RESP_FAILED = 2'b10;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'b11;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [1:0]            op;
    logic [31:0]           data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping.
module dmi_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan requesters starting at the pointer and keep the first hit.
  always_comb begin
    int                 c;
    logic [IDX_W-1:0]   w_cand;
    c        = 0;
    w_cand   = '0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(i_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      w_cand = IDX_W'(c);
      if (!o_any && i_valid[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_any) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI slave port among NUM_REQ masters: one transaction in flight,
// round-robin grant, response routed to the issuer, timeout returns FAILED.
module dmi_req_arbiter
  import dm_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic      [NUM_REQ-1:0] req_valid_i,
  output logic      [NUM_REQ-1:0] req_ready_o,
  input  dmi_req_t  [NUM_REQ-1:0] req_i,
  output logic      [NUM_REQ-1:0] resp_valid_o,
  input  logic      [NUM_REQ-1:0] resp_ready_i,
  output dmi_resp_t               resp_o,
  output logic                    dm_req_valid_o,
  input  logic                    dm_req_ready_i,
  output dmi_req_t                dm_req_o,
  input  logic                    dm_resp_valid_i,
  output logic                    dm_resp_ready_o,
  input  dmi_resp_t               dm_resp_i
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELIVER
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_stale;
  logic [TMR_W-1:0]   r_timer;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_op;
  logic [31:0]        r_data;
  dmi_resp_t          r_resp;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [NUM_REQ-1:0] w_owner_oh;
  dmi_req_t           w_sel;
  logic               w_grant;
  logic               w_dm_hs;
  logic               w_resp_hit;
  logic               w_timeout;
  logic               w_deliver_done;

  dmi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_valid  (req_valid_i),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_sel    = req_i[w_pick_idx];
  assign dm_req_o = '{addr: r_addr, op: r_op, data: r_data};
  assign resp_o   = r_resp;

  // Decode the owning master into a one-hot response-valid mask.
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  // Next-state and handshake outputs; a stale transaction keeps the DM response
  // channel drained and blocks new grants so late data is never mis-routed.
  always_comb begin
    w_state_nxt     = r_state;
    req_ready_o     = '0;
    resp_valid_o    = '0;
    dm_req_valid_o  = 1'b0;
    dm_resp_ready_o = r_stale;
    w_grant         = 1'b0;
    w_dm_hs         = 1'b0;
    w_resp_hit      = 1'b0;
    w_timeout       = 1'b0;
    w_deliver_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any && !r_stale) begin
          w_grant     = 1'b1;
          req_ready_o = w_pick_oh;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dm_req_valid_o = 1'b1;
        if (dm_req_ready_i) begin
          w_dm_hs     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dm_resp_ready_o = 1'b1;
        if (dm_resp_valid_i) begin
          w_resp_hit  = 1'b1;
          w_state_nxt = ST_DELIVER;
        end else if (TO_EN && (r_timer == TMR_W'(TO_LAST))) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        resp_valid_o = w_owner_oh;
        if (resp_ready_i[r_owner]) begin
          w_deliver_done = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request capture, response capture, ownership, round-robin pointer, timer and stale flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_stale  <= 1'b0;
      r_timer  <= '0;
      r_addr   <= '0;
      r_op     <= '0;
      r_data   <= '0;
      r_resp   <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_pick_idx;
        r_addr  <= w_sel.addr;
        r_op    <= w_sel.op;
        r_data  <= w_sel.data;
      end
      if (w_dm_hs) begin
        r_timer <= '0;
      end else if (TO_EN && (r_state == ST_WAIT) && !dm_resp_valid_i && !w_timeout) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_resp_hit) begin
        r_resp <= dm_resp_i;
      end else if (w_timeout) begin
        r_resp <= '{data: 32'h0, resp: DMI_RESP_FAILED};
      end
      if (w_timeout) begin
        r_stale <= 1'b1;
      end else if (r_stale && dm_resp_valid_i && (r_state != ST_WAIT)) begin
        r_stale <= 1'b0;
      end
      if (w_deliver_done) begin
        r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
      end
    end
  end

endmodule
